// File: rtl/tone_meter_if.sv
// ============================================================================
// Module   : tone_meter_if
// Brief    : CPU-side control and result handshake of the tone meter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface tone_meter_if #(
    parameter int COUNT_WIDTH = 26
);
    logic                   enable;
    logic                   read_ack;
    logic [COUNT_WIDTH-1:0] measured_count;
    logic                   count_valid;
    logic                   overrun;

    modport master (
        output enable,
        output read_ack,
        input  measured_count,
        input  count_valid,
        input  overrun
    );

    modport slave (
        input  enable,
        input  read_ack,
        output measured_count,
        output count_valid,
        output overrun
    );
endinterface

`default_nettype wire

// File: rtl/tone_meter.sv
// ============================================================================
// Module   : tone_meter
// Brief    : Measures the half-period of an external square wave and reports
//            it in buzzer max_count encoding (cycles-1, 0 = silent).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tone_meter #(
    parameter int COUNT_WIDTH = 26,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 25000000
) (
    input  wire logic   clk,
    input  wire logic   rst_async_n,
    input  wire logic   tone_in,
    tone_meter_if.slave bus
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ARM     = 2'd1;
    localparam logic [1:0] c_ST_MEASURE = 2'd2;

    localparam logic [COUNT_WIDTH-1:0] c_ONE          = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] c_TIMEOUT_LAST = COUNT_WIDTH'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic                   w_edge;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [COUNT_WIDTH-1:0] r_counter;
    logic [COUNT_WIDTH-1:0] w_counter_next;
    logic                   w_publish;
    logic [COUNT_WIDTH-1:0] w_pub_value;

    logic [COUNT_WIDTH-1:0] r_measured;
    logic                   r_valid;
    logic                   r_overrun;

    assign w_edge = r_sync[SYNC_STAGES-1] ^ r_sync_d;

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], tone_in};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            r_state   <= c_ST_IDLE;
            r_counter <= '0;
        end else begin
            r_state   <= w_state_next;
            r_counter <= w_counter_next;
        end
    end

    // Counter defaults to 0 so every exit path (edge, timeout, idle) restarts it.
    always_comb begin
        w_state_next   = r_state;
        w_counter_next = '0;
        w_publish      = 1'b0;
        w_pub_value    = '0;
        if (!bus.enable) begin
            w_state_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: w_state_next = c_ST_ARM;
                c_ST_ARM: begin
                    if (w_edge) begin
                        w_state_next = c_ST_MEASURE;
                    end
                end
                c_ST_MEASURE: begin
                    if (w_edge) begin
                        w_publish   = 1'b1;
                        w_pub_value = (r_counter == '0) ? c_ONE : r_counter;
                    end else if (r_counter == c_TIMEOUT_LAST) begin
                        w_publish    = 1'b1;
                        w_state_next = c_ST_ARM;
                    end else begin
                        w_counter_next = r_counter + c_ONE;
                    end
                end
                default: w_state_next = c_ST_IDLE;
            endcase
        end
    end

    // A publish coinciding with an ack counts as consumed-then-refilled: no overrun.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            r_measured <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (w_publish) begin
            r_measured <= w_pub_value;
            r_valid    <= 1'b1;
            if (r_valid) begin
                r_overrun <= !bus.read_ack;
            end
        end else if (bus.read_ack && r_valid) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign bus.measured_count = r_measured;
    assign bus.count_valid    = r_valid;
    assign bus.overrun        = r_overrun;

endmodule

`default_nettype wire
